same_image_passthrough: RTL and testbench
=========================================

Name: same_image_passthrough

Overview:
- Pixel-stream pass-through for the image-verification path. Each 8-bit greyscale pixel presented on data_in appears unchanged on data_out with zero latency, so the output image is bit-identical to the input image.
- Adds registered frame bookkeeping for downstream checkers: column, row and pixel counters, an end-of-frame pulse, and a frame counter.
- Sits between the pixel source (memory or file reader) and the pixel sink.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 128, pixels per row.
- IMG_H, 128, rows per frame (default frame is 16384 pixels).
- FRAME_CNT_W, 8, width of the frame counter.

Ports:
- clk  input  1  rising-edge clock; one pixel per cycle.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- data_in  input  DATA_W  incoming pixel.
- data_out  output  DATA_W  outgoing pixel, identical to data_in.
- col  output  $clog2(IMG_W)  column index of the pixel accepted this cycle.
- row  output  $clog2(IMG_H)  row index of the pixel accepted this cycle.
- pix_cnt  output  $clog2(IMG_W*IMG_H)  linear pixel index within the frame.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_cnt  output  FRAME_CNT_W  number of completed frames.

Behaviour:
- data_out = data_in, purely combinational with zero latency. It is not gated by reset and not affected by clk.
- Reset (rst=0, asynchronous): col, row, pix_cnt, frame_cnt and frame_done all go to 0. All registers are held at 0 while rst=0.
- After reset releases, each rising clk edge accepts one pixel, and the counters reflect the next pixel position:
  - col increments each cycle.
  - At col = IMG_W-1, col wraps to 0 and row increments.
  - At col = IMG_W-1 and row = IMG_H-1, both wrap to 0, pix_cnt wraps to 0, frame_done = 1 for exactly one cycle, and frame_cnt increments.
- pix_cnt always equals row*IMG_W + col.
- frame_cnt wraps modulo 2^FRAME_CNT_W with no saturation.
- Reset asserted mid-frame: counters clear immediately and the next frame starts at pixel 0. The partial frame does not count and does not produce frame_done.
- There is no handshake or backpressure; the source must present one valid pixel per cycle.
- All sequential logic uses the single clk domain with an asynchronous active-low reset.

Optional Feature:
- Macro: SAMEIMAGE_CHECKSUM_EN.
- When defined, the block adds output checksum [15:0] and output checksum_valid [0:0]:
  - checksum is the modulo-2^16 sum of all pixels accepted in the current frame.
  - At frame end, the final sum, including the last pixel, is held on checksum and checksum_valid pulses together with frame_done.
  - The accumulator restarts at 0 for the next frame.
  - Reset clears both outputs.
- When not defined, neither port nor the accumulator logic exists, and all other behaviour is unchanged.

Test Plan:
- Zero-latency pass-through: drive data_in = 0x00, 0x7F, 0xFF, 0xA5 in turn, including while rst=0 -> data_out equals data_in at every step, with no clock delay.
- Full frame: after reset release, stream 16384 pixels from a 128x128 image file -> the captured output file is byte-identical to the input; frame_done pulses once, at the cycle after pixel 16383; frame_cnt = 1.
- Counter wrap: stream 130 pixels -> after 128 edges col=0 and row=1; after 130 edges col=2, row=1, pix_cnt=130.
- Reset mid-frame: assert rst=0 after 5000 pixels, release, then stream 16384 pixels -> counters restart at 0, frame_done pulses exactly once, frame_cnt = 1.
- Frame counter wrap: stream 256 frames with FRAME_CNT_W=8 -> frame_cnt returns to 0 and frame_done has pulsed 256 times.
- Checksum (with SAMEIMAGE_CHECKSUM_EN): stream a frame of all 0x01 -> checksum = 0x4000 with checksum_valid aligned to frame_done; a frame of all 0xFF -> checksum = 0xC000 (16384*255 mod 65536).

Source files
------------

// File: rtl/same_image_passthrough.sv
// -----------------------------------------------------------------------------
// same_image_passthrough
//
// Pixel-stream pass-through for the image-verification path. The pixel on
// data_in is copied to data_out combinationally, so the output image is
// bit-identical to the input image. The block also keeps registered frame
// bookkeeping for downstream checkers. There is no handshake: the source must
// present one valid pixel on every clock.
//
// Build option:
//   SAMEIMAGE_CHECKSUM_EN  adds a per-frame modulo-2^16 pixel checksum
//                          (ports checksum / checksum_valid).
//
// Ports:
//   clk            rising-edge clock, one pixel accepted per edge
//   rst            asynchronous reset, active low (asserted when 0)
//   data_in        incoming pixel
//   data_out       outgoing pixel, identical to data_in, zero latency
//   col            column of the next pixel position (edges since reset mod IMG_W)
//   row            row of the next pixel position
//   pix_cnt        linear index row*IMG_W + col
//   frame_done     one-cycle pulse after the last pixel of a frame is accepted
//   frame_cnt      number of completed frames, wraps modulo 2^FRAME_CNT_W
//   checksum       (option) sum of pixels accepted in the current frame;
//                  holds the final frame sum while checksum_valid is high
//   checksum_valid (option) pulses together with frame_done
// -----------------------------------------------------------------------------
module same_image_passthrough #(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                data_in,
  output logic [DATA_W-1:0]                data_out,
  output logic [$clog2(IMG_W)-1:0]         col,
  output logic [$clog2(IMG_H)-1:0]         row,
  output logic [$clog2(IMG_W*IMG_H)-1:0]   pix_cnt,
  output logic                             frame_done,
  output logic [FRAME_CNT_W-1:0]           frame_cnt
`ifdef SAMEIMAGE_CHECKSUM_EN
  ,
  output logic [15:0]                      checksum,
  output logic                             checksum_valid
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int PIX_W = $clog2(IMG_W * IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // ---------------------------------------------------------------------------
  // Data path: a plain wire, independent of clock and reset.
  // ---------------------------------------------------------------------------
  assign data_out = data_in;

  // ---------------------------------------------------------------------------
  // Frame bookkeeping
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0]       col_reg,        col_next;
  logic [ROW_W-1:0]       row_reg,        row_next;
  logic [PIX_W-1:0]       pix_reg,        pix_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg,  frame_cnt_next;
  logic                   frame_done_reg, frame_done_next;
  logic                   col_end;
  logic                   row_end;
  logic                   frame_end;

  always_comb begin
    col_end         = (col_reg == COL_LAST);
    row_end         = (row_reg == ROW_LAST);
    // The pixel being accepted on this edge is the last one of the frame.
    frame_end       = col_end && row_end;

    col_next        = col_end ? '0 : col_reg + COL_W'(1);
    row_next        = row_reg;
    if (col_end) begin
      row_next      = row_end ? '0 : row_reg + ROW_W'(1);
    end
    // pix_cnt is advanced in lockstep with col/row instead of being computed
    // as row*IMG_W + col, which avoids a multiplier on the output path.
    pix_next        = frame_end ? '0 : pix_reg + PIX_W'(1);
    frame_cnt_next  = frame_end ? frame_cnt_reg + FRAME_CNT_W'(1) : frame_cnt_reg;
    frame_done_next = frame_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      pix_reg        <= '0;
      frame_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      pix_reg        <= pix_next;
      frame_cnt_reg  <= frame_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign col        = col_reg;
  assign row        = row_reg;
  assign pix_cnt    = pix_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign frame_done = frame_done_reg;

`ifdef SAMEIMAGE_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Per-frame checksum. sum_reg always holds the sum of the pixels accepted so
  // far in the current frame. On the cycle after the last pixel it therefore
  // holds the complete frame sum, which is exactly when frame_done is high;
  // the first pixel of the next frame then reloads the sum instead of adding.
  // ---------------------------------------------------------------------------
  logic [15:0] sum_reg, sum_next;

  always_comb begin
    sum_next = frame_done_reg ? 16'(data_in) : sum_reg + 16'(data_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
    end
  end

  assign checksum       = sum_reg;
  assign checksum_valid = frame_done_reg;
`endif

endmodule

// File: tb/tb_same_image_passthrough.sv
// -----------------------------------------------------------------------------
// tb_same_image_passthrough
//
// Two instances share clock, reset and pixel stream: the default 128x128
// configuration and a tiny 4x2 one so that a full frame-counter wrap (256
// frames) fits in a short run. A reference model counts accepted pixels since
// reset and keeps prefix sums of the pixel stream; every expected output is
// derived from that count with plain arithmetic. A compare process checks
// both instances on every falling edge, and the stimulus process adds literal
// checkpoints.
// -----------------------------------------------------------------------------
module tb_same_image_passthrough;

  localparam int  F_M = 128 * 128;  // main instance frame size
  localparam int  W_S = 4;
  localparam int  H_S = 2;
  localparam int  F_S = W_S * H_S;  // small instance frame size

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_in = 8'h00;

  logic [7:0]  data_out;
  logic [6:0]  col;
  logic [6:0]  row;
  logic [13:0] pix_cnt;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  logic [7:0]  data_out_s;
  logic [1:0]  col_s;
  logic [0:0]  row_s;
  logic [2:0]  pix_cnt_s;
  logic        frame_done_s;
  logic [7:0]  frame_cnt_s;

`ifdef SAMEIMAGE_CHECKSUM_EN
  logic [15:0] checksum, checksum_s;
  logic        checksum_valid, checksum_valid_s;
`endif

  same_image_passthrough dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out),
    .col        (col),
    .row        (row),
    .pix_cnt    (pix_cnt),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
`ifdef SAMEIMAGE_CHECKSUM_EN
    ,
    .checksum       (checksum),
    .checksum_valid (checksum_valid)
`endif
  );

  same_image_passthrough #(
    .DATA_W      (8),
    .IMG_W       (W_S),
    .IMG_H       (H_S),
    .FRAME_CNT_W (8)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out_s),
    .col        (col_s),
    .row        (row_s),
    .pix_cnt    (pix_cnt_s),
    .frame_done (frame_done_s),
    .frame_cnt  (frame_cnt_s)
`ifdef SAMEIMAGE_CHECKSUM_EN
    ,
    .checksum       (checksum_s),
    .checksum_valid (checksum_valid_s)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: n = pixels accepted since reset, psum[k] = sum of the
  // first k pixels accepted since reset.
  // ---------------------------------------------------------------------------
  longint n = 0;
  longint psum[$];

  initial begin
    psum.push_back(0);
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        n = 0;
        psum.delete();
        psum.push_back(0);
      end else begin
        psum.push_back(psum[n] + longint'(data_in));
        n = n + 1;
      end
    end
  end

  function automatic longint e_fd(longint f);
    return (n > 0 && (n % f) == 0) ? 1 : 0;
  endfunction

  function automatic longint e_fc(longint f);
    return (n / f) % 256;
  endfunction

  function automatic longint e_sum(longint f);
    longint start;
    if (n == 0) return 0;
    start = ((n - 1) / f) * f;
    return (psum[n] - psum[start]) % 65536;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (pixels since reset %0d, t=%0t)",
               name, act, exp, n, $time);
    end
  endtask

  int fd_pulses   = 0;
  int fd_pulses_s = 0;

  always @(negedge clk) begin
    chk("data_out",     data_out,     data_in);
    chk("col",          col,          n % 128);
    chk("row",          row,          (n / 128) % 128);
    chk("pix_cnt",      pix_cnt,      n % F_M);
    chk("frame_done",   frame_done,   e_fd(F_M));
    chk("frame_cnt",    frame_cnt,    e_fc(F_M));
    chk("s_data_out",   data_out_s,   data_in);
    chk("s_col",        col_s,        n % W_S);
    chk("s_row",        row_s,        (n / W_S) % H_S);
    chk("s_pix_cnt",    pix_cnt_s,    n % F_S);
    chk("s_frame_done", frame_done_s, e_fd(F_S));
    chk("s_frame_cnt",  frame_cnt_s,  e_fc(F_S));
`ifdef SAMEIMAGE_CHECKSUM_EN
    chk("checksum",         checksum,         e_sum(F_M));
    chk("checksum_valid",   checksum_valid,   e_fd(F_M));
    chk("s_checksum",       checksum_s,       e_sum(F_S));
    chk("s_checksum_valid", checksum_valid_s, e_fd(F_S));
`endif
    if (frame_done === 1'b1)   fd_pulses++;
    if (frame_done_s === 1'b1) fd_pulses_s++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic pixel(input logic [7:0] d);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pt_vals [4] = '{8'h00, 8'h7F, 8'hFF, 8'hA5};
  int snap;

  initial begin
    // Pass-through while held in reset: no clock needed.
    for (int i = 0; i < 4; i++) begin
      data_in = pt_vals[i];
      #1;
      chk("passthru_in_reset", data_out, pt_vals[i]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_col", col, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    rst = 1'b1;

    // Counter wrap, then the rest of a full frame.
    for (int k = 0; k < F_M; k++) begin
      if (k < 4) begin
        data_in = pt_vals[k];
        #1;
        chk("passthru_run", data_out, pt_vals[k]);
        @(posedge clk); #1;
      end else begin
        pixel(8'($urandom));
      end
      if (k == 127) begin
        chk("wrap128_col", col, 0);
        chk("wrap128_row", row, 1);
      end
      if (k == 129) begin
        chk("wrap130_col", col, 2);
        chk("wrap130_row", row, 1);
        chk("wrap130_pix", pix_cnt, 130);
      end
    end
    chk("frame1_done", frame_done, 1);
    chk("frame1_cnt", frame_cnt, 1);
    chk("frame1_pix", pix_cnt, 0);
    pixel(8'($urandom));
    chk("frame1_done_off", frame_done, 0);
    chk("frame1_pulses", fd_pulses, 1);

    // Reset in the middle of a frame (5000 pixels into frame 2).
    for (int k = 1; k < 5000; k++) pixel(8'($urandom));
    chk("mid_pix_before", pix_cnt, 5000);
    rst = 1'b0;
    #1;
    chk("mid_rst_col", col, 0);
    chk("mid_rst_row", row, 0);
    chk("mid_rst_pix", pix_cnt, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_done", frame_done, 0);
    snap = fd_pulses;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Frame of all 0x01 after the reset.
    for (int k = 0; k < F_M; k++) pixel(8'h01);
    chk("ones_done", frame_done, 1);
    chk("ones_frame_cnt", frame_cnt, 1);
`ifdef SAMEIMAGE_CHECKSUM_EN
    chk("ones_checksum", checksum, 16'h4000);
    chk("ones_checksum_valid", checksum_valid, 1);
`endif
    // Frame of all 0xFF.
    for (int k = 0; k < F_M; k++) begin
      pixel(8'hFF);
      if (k == 0) chk("ones_pulses", fd_pulses - snap, 1);
    end
    chk("ff_done", frame_done, 1);
    chk("ff_frame_cnt", frame_cnt, 2);
`ifdef SAMEIMAGE_CHECKSUM_EN
    chk("ff_checksum", checksum, 16'hC000);
    chk("ff_checksum_valid", checksum_valid, 1);
`endif

    // Frame counter wrap on the small instance: 256 frames of 8 pixels.
    rst = 1'b0;
    @(posedge clk); #1;
    snap = fd_pulses_s;
    rst = 1'b1;
    for (int k = 0; k < 256 * F_S; k++) pixel(8'($urandom));
    chk("s_wrap_frame_cnt", frame_cnt_s, 0);
    chk("s_wrap_done", frame_done_s, 1);
    chk("main_after_2048_pix", pix_cnt, 2048);
    pixel(8'($urandom));
    chk("s_wrap_pulses", fd_pulses_s - snap, 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
